uart_program_loader: RTL and testbench

Serial program loader for the MC14500B core. It receives 8N1 UART bytes on rx, packs byte pairs into DATA_WIDTH-bit instruction words, and drives the write port of the text RAM (program_write, program_cmd, uart_address). It is the writer side of the text RAM, which the program counter reads. loading stays high for the whole session so the top level can hold the core in reset.

---
 rtl/uart_program_loader.sv | 273 +++++++++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// ------------------------------------------------------------------------------------------------
// uart_program_loader
//
// Serial program loader for the MC14500B core. Receives 8N1 UART bytes on rx, packs byte pairs
// into DATA_WIDTH-bit instruction words and drives the write port of the text RAM. loading stays
// high for the whole session so the top level can hold the core in reset.
//
// Word framing: first byte carries word bits [DATA_WIDTH-1:8] in its low (DATA_WIDTH-8) bits, the
// remaining high bits must be zero. Second byte carries word bits [7:0]. A first byte of 8'hFF is
// the end-of-session marker.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   rx             UART serial input, idle high, asynchronous to clk
//   program_write  one-cycle text RAM write strobe
//   program_cmd    word to write, valid while program_write=1, holds between writes
//   uart_address   text RAM write address
//   loading        load session active
//   done           one-cycle pulse at end of session
//   frame_error    sticky error flag, cleared when a new session starts
//
// Optional feature macro: LOADER_TIMEOUT_EN
//   Defined   - a second byte that does not arrive within TIMEOUT_BITS bit times drops the
//               pending first byte and sets frame_error.
//   Undefined - the loader waits for the second byte indefinitely; no timeout counter exists.
// ------------------------------------------------------------------------------------------------
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned TIMEOUT_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  program_write,
    output logic [DATA_WIDTH-1:0] program_cmd,
    output logic [ADDR_WIDTH-1:0] uart_address,
    output logic                  loading,
    output logic                  done,
    output logic                  frame_error
);

    localparam int unsigned H       = DATA_WIDTH - 8;
    localparam int unsigned BitCntW = $clog2(CLKS_PER_BIT);
    localparam logic [BitCntW-1:0] FullBit = BitCntW'(CLKS_PER_BIT - 1);
    localparam logic [BitCntW-1:0] HalfBit = BitCntW'(CLKS_PER_BIT / 2 - 1);
    // Bits of the first byte that must be zero for a valid word header.
    localparam logic [7:0] HiMask = 8'hFF << H;

    // RX FSM encoding
    localparam logic [2:0] RxIdle     = 3'd0;
    localparam logic [2:0] RxStart    = 3'd1;
    localparam logic [2:0] RxData     = 3'd2;
    localparam logic [2:0] RxStop     = 3'd3;
    localparam logic [2:0] RxWaitHigh = 3'd4;

    // Word FSM encoding
    localparam logic WHi = 1'b0;
    localparam logic WLo = 1'b1;

    // --------------------------------------------------------------------------------------------
    // rx synchronizer, preset to the idle level
    // --------------------------------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // --------------------------------------------------------------------------------------------
    // RX FSM
    // --------------------------------------------------------------------------------------------
    logic [2:0]         rx_state_q, rx_state_d;
    logic [BitCntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               byte_valid_q, byte_valid_d;
    logic               stop_err_q, stop_err_d;

    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        stop_err_d   = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_sync_q) rx_state_d = RxStart;
            end
            RxStart: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (clk_cnt_q == HalfBit) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (clk_cnt_q == FullBit) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (clk_cnt_q == FullBit) begin
                    clk_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        rx_state_d   = RxIdle;
                    end else begin
                        stop_err_d = 1'b1;
                        rx_state_d = RxWaitHigh;
                    end
                end
            end
            RxWaitHigh: begin
                // A held-low line (break) stays here, so it yields a single error.
                clk_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RxIdle;
            end
            default: begin
                clk_cnt_d  = '0;
                rx_state_d = RxIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q   <= RxIdle;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            stop_err_q   <= stop_err_d;
        end
    end

    // --------------------------------------------------------------------------------------------
    // Optional inter-byte timeout while waiting for the second byte
    // --------------------------------------------------------------------------------------------
    logic word_state_q, word_state_d;
    logic timeout;

`ifdef LOADER_TIMEOUT_EN
    localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned ToW           = $clog2(TimeoutCycles + 1);
    localparam logic [ToW-1:0] ToLast     = ToW'(TimeoutCycles - 1);

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
    logic           to_run;

    always_comb begin
        to_run   = (word_state_q == WLo) && !byte_valid_q && !stop_err_q;
        timeout  = to_run && (to_cnt_q == ToLast);
        to_cnt_d = (to_run && !timeout) ? to_cnt_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    // --------------------------------------------------------------------------------------------
    // Word FSM and text RAM write port
    // --------------------------------------------------------------------------------------------
    logic [H-1:0]          hi_q, hi_d;
    logic [DATA_WIDTH-1:0] cmd_q, cmd_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  loading_q, loading_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;

    always_comb begin
        word_state_d = word_state_q;
        hi_d         = hi_q;
        cmd_d        = cmd_q;
        write_d      = 1'b0;
        addr_d       = addr_q;
        loading_d    = loading_q;
        done_d       = 1'b0;
        ferr_d       = ferr_q;

        // Address advances on the edge after the write strobe, wrapping silently.
        if (write_q) addr_d = addr_q + 1'b1;

        if (stop_err_q) begin
            ferr_d       = 1'b1;
            word_state_d = WHi;
        end else if (byte_valid_q) begin
            case (word_state_q)
                WHi: begin
                    if (shift_q == 8'hFF) begin
                        done_d    = 1'b1;
                        loading_d = 1'b0;
                        addr_d    = '0;
                    end else if ((shift_q & HiMask) == 8'h00) begin
                        if (!loading_q) begin
                            loading_d = 1'b1;
                            ferr_d    = 1'b0;
                            addr_d    = '0;
                        end
                        hi_d         = shift_q[H-1:0];
                        word_state_d = WLo;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: begin
                    cmd_d        = {hi_q, shift_q};
                    write_d      = 1'b1;
                    word_state_d = WHi;
                end
            endcase
        end else if (timeout) begin
            ferr_d       = 1'b1;
            word_state_d = WHi;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_state_q <= WHi;
            hi_q         <= '0;
            cmd_q        <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            loading_q    <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            word_state_q <= word_state_d;
            hi_q         <= hi_d;
            cmd_q        <= cmd_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            loading_q    <= loading_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
        end
    end

    assign program_write = write_q;
    assign program_cmd   = cmd_q;
    assign uart_address  = addr_q;
    assign loading       = loading_q;
    assign done          = done_q;
    assign frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// ------------------------------------------------------------------------------------------------
// tb_uart_program_loader
//
// Self-checking bench for uart_program_loader (ADDR_WIDTH=8, DATA_WIDTH=12). A table of framed
// bytes with expected outcomes drives the main session, break and invalid-header cases; hand
// sequences cover the glitch, mid-byte reset and optional timeout; a random session of 257 words
// checks packing and address wrap against values computed directly from the word list.
// ------------------------------------------------------------------------------------------------
module tb_uart_program_loader;

    localparam int unsigned CPB = 12;
    localparam int unsigned AW  = 8;
    localparam int unsigned DW  = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx;
    logic          program_write;
    logic [DW-1:0] program_cmd;
    logic [AW-1:0] uart_address;
    logic          loading;
    logic          done;
    logic          frame_error;

    uart_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .TIMEOUT_BITS(32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .program_write(program_write),
        .program_cmd  (program_cmd),
        .uart_address (uart_address),
        .loading      (loading),
        .done         (done),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Write/done monitor, sampled on the falling edge.
    logic [AW-1:0] wr_addr[$];
    logic [DW-1:0] wr_cmd[$];
    int            done_cnt = 0;
    int            b2b_cnt  = 0;
    logic          prev_wr  = 1'b0;

    always @(negedge clk) begin
        if (program_write) begin
            wr_addr.push_back(uart_address);
            wr_cmd.push_back(program_cmd);
            if (prev_wr) b2b_cnt++;
        end
        if (done) done_cnt++;
        prev_wr = program_write;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // One 8N1 frame; optionally hold the line low for extra bit times after the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int hold_bits);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop_ok);
        for (int i = 0; i < hold_bits; i++) bit_time(1'b0);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        stop_ok;
        int          hold_bits;
        logic        exp_wr;
        logic [11:0] exp_cmd;
        logic [7:0]  exp_waddr;
        logic [7:0]  exp_uaddr;
        logic        exp_load;
        logic        exp_ferr;
        logic        exp_done;
    } vec_t;

    vec_t        vecs[13];
    logic [11:0] words[257];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nw0;
        int   nd0;
        int   base;
        logic junk;

        //          data   stop  hold  wr    cmd      waddr  uaddr  load  ferr  done
        vecs[0]  = '{8'h03, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{8'h45, 1'b1, 0,  1'b1, 12'h345, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h0A, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{8'hBC, 1'b1, 0,  1'b1, 12'hABC, 8'h01, 8'h02, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{8'hFF, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{8'h12, 1'b0, 50, 1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{8'h01, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{8'h02, 1'b1, 0,  1'b1, 12'h102, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{8'h30, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{8'h00, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{8'h11, 1'b1, 0,  1'b1, 12'h011, 8'h01, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{8'hFF, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[12] = '{8'hFF, 1'b1, 0,  1'b0, 12'h000, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};

        // Reset state
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_write", 32'(program_write), 32'd0);
        check("rst_cmd", 32'(program_cmd), 32'd0);
        check("rst_addr", 32'(uart_address), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven session, break and invalid-header cases
        for (int i = 0; i < 13; i++) begin
            nw0 = wr_cmd.size();
            nd0 = done_cnt;
            send_byte(vecs[i].data, vecs[i].stop_ok, vecs[i].hold_bits);
            check($sformatf("v%0d_nwrites", i), 32'(wr_cmd.size() - nw0), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr && wr_cmd.size() > nw0) begin
                check($sformatf("v%0d_cmd", i), 32'(wr_cmd[nw0]), 32'(vecs[i].exp_cmd));
                check($sformatf("v%0d_waddr", i), 32'(wr_addr[nw0]), 32'(vecs[i].exp_waddr));
            end
            check($sformatf("v%0d_uaddr", i), 32'(uart_address), 32'(vecs[i].exp_uaddr));
            check($sformatf("v%0d_loading", i), 32'(loading), 32'(vecs[i].exp_load));
            check($sformatf("v%0d_ferr", i), 32'(frame_error), 32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_ndone", i), 32'(done_cnt - nd0), 32'(vecs[i].exp_done));
        end

        // Short low glitch: rejected in START, nothing changes
        nw0 = wr_cmd.size();
        nd0 = done_cnt;
        rx  = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        check("glitch_nwrites", 32'(wr_cmd.size() - nw0), 32'd0);
        check("glitch_ndone", 32'(done_cnt - nd0), 32'd0);
        check("glitch_loading", 32'(loading), 32'd0);
        check("glitch_ferr", 32'(frame_error), 32'd1);
        check("glitch_uaddr", 32'(uart_address), 32'd0);
        check("glitch_cmd", 32'(program_cmd), 32'h011);

        // Reset in the middle of the second byte of a word
        send_byte(8'h05, 1'b1, 0);
        check("rstmid_loading_pre", 32'(loading), 32'd1);
        check("rstmid_ferr_pre", 32'(frame_error), 32'd0);
        nw0 = wr_cmd.size();
        rx  = 1'b0;
        repeat (5 * CPB) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstmid_write", 32'(program_write), 32'd0);
        check("rstmid_cmd", 32'(program_cmd), 32'd0);
        check("rstmid_addr", 32'(uart_address), 32'd0);
        check("rstmid_loading", 32'(loading), 32'd0);
        check("rstmid_ferr", 32'(frame_error), 32'd0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        check("rstmid_nwrites", 32'(wr_cmd.size() - nw0), 32'd0);
        send_byte(8'h05, 1'b1, 0);
        send_byte(8'h66, 1'b1, 0);
        check("rstmid_after_nwrites", 32'(wr_cmd.size() - nw0), 32'd1);
        if (wr_cmd.size() > nw0) begin
            check("rstmid_after_cmd", 32'(wr_cmd[nw0]), 32'h566);
            check("rstmid_after_waddr", 32'(wr_addr[nw0]), 32'd0);
        end
        send_byte(8'hFF, 1'b1, 0);

`ifdef LOADER_TIMEOUT_EN
        // Missing second byte: pending header dropped after the timeout
        nw0 = wr_cmd.size();
        send_byte(8'h05, 1'b1, 0);
        repeat (33 * CPB) @(negedge clk);
        check("timeout_ferr", 32'(frame_error), 32'd1);
        check("timeout_loading", 32'(loading), 32'd1);
        check("timeout_nwrites", 32'(wr_cmd.size() - nw0), 32'd0);
        send_byte(8'hFF, 1'b1, 0);
`endif

        // Random session of 257 words with occasional invalid headers; address must wrap
        base = wr_cmd.size();
        junk = 1'b0;
        for (int k = 0; k < 257; k++) begin
            words[k] = 12'($urandom_range(0, 4095));
            if (k > 0 && $urandom_range(0, 15) == 0) begin
                send_byte(8'($urandom_range(16, 254)), 1'b1, 0);
                junk = 1'b1;
            end
            send_byte({4'h0, words[k][11:8]}, 1'b1, 0);
            send_byte(words[k][7:0], 1'b1, 0);
        end
        check("wrap_nwrites", 32'(wr_cmd.size() - base), 32'd257);
        for (int k = 0; k < 257; k++) begin
            if (base + k < wr_cmd.size()) begin
                check($sformatf("wrap_waddr%0d", k), 32'(wr_addr[base + k]), 32'(k % 256));
                check($sformatf("wrap_cmd%0d", k), 32'(wr_cmd[base + k]), 32'(words[k]));
            end
        end
        check("wrap_loading", 32'(loading), 32'd1);
        check("wrap_ferr", 32'(frame_error), 32'(junk));
        check("wrap_uaddr", 32'(uart_address), 32'd1);
        send_byte(8'hFF, 1'b1, 0);
        check("end_loading", 32'(loading), 32'd0);
        check("end_uaddr", 32'(uart_address), 32'd0);

        check("write_spacing", 32'(b2b_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
